// File: rtl/enemy_controller.sv
// Per-frame sequencer for a bank of enemies sharing one VGA write port: broadcasts the
// move-phase strobes, then requests the port and draws each live enemy in turn.
module enemy_controller #(
    parameter int NUM_ENEMIES  = 4,
    parameter int SEL_W        = 2,
    parameter int MOVE_DIV     = 2,
    parameter int DRAW_TIMEOUT = 300
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   frame_tick,
    input  logic [NUM_ENEMIES-1:0] alive,
    input  logic [NUM_ENEMIES-1:0] enemy_draw_done,
    input  logic                   draw_grant,
    output logic                   init,
    output logic                   idle,
    output logic                   gen_move,
    output logic                   apply_move,
    output logic [NUM_ENEMIES-1:0] draw_en,
    output logic [SEL_W-1:0]       draw_sel,
    output logic                   draw_req,
    output logic                   frame_done,
    output logic                   overrun
);

    typedef enum logic [3:0] {
        S_OFF,
        S_INIT,
        S_WAIT,
        S_GEN,
        S_CHECK,
        S_APPLY,
        S_REQ,
        S_DRAW,
        S_GAP,
        S_DONE
    } state_t;

    state_t                 state, state_next;
    logic [3:0]             frame_cnt, frame_cnt_next;
    logic                   pending, pending_next;
    logic                   overrun_next;
    logic [8:0]             watchdog, watchdog_next;
    logic [SEL_W-1:0]       sel_next;
    logic                   first_found, next_found;
    logic [SEL_W-1:0]       first_idx, next_idx;
    logic                   done_hit;

    logic                   init_next, idle_next, gen_move_next, apply_move_next;
    logic                   draw_req_next, frame_done_next;
    logic [NUM_ENEMIES-1:0] draw_en_next;

    // draw_en is one-hot on the selected enemy, so this ignores every other done line.
    assign done_hit = |(enemy_draw_done & draw_en);

    // Descending scan so the lowest qualifying index is the one left standing.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
            if (alive[i]) begin
                first_found = 1'b1;
                first_idx   = SEL_W'(i);
            end
            if (alive[i] && (i > int'(draw_sel))) begin
                next_found = 1'b1;
                next_idx   = SEL_W'(i);
            end
        end
    end

    // NOTE: every variable is given a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_next     = state;
        frame_cnt_next = frame_cnt;
        pending_next   = pending;
        overrun_next   = overrun;
        watchdog_next  = watchdog;
        sel_next       = draw_sel;

        if (frame_tick && (state != S_WAIT)) begin
            if (pending) overrun_next = 1'b1;
            else         pending_next = 1'b1;
        end

        unique case (state)
            S_OFF:   state_next = S_OFF;
            S_INIT: begin
                frame_cnt_next = '0;
                pending_next   = 1'b0;
                state_next     = S_WAIT;
            end
            S_WAIT: begin
                if (frame_tick || pending) begin
                    pending_next = 1'b0;
                    if (frame_cnt == 4'(MOVE_DIV - 1)) begin
                        frame_cnt_next = '0;
                        state_next     = S_GEN;
                    end else begin
                        frame_cnt_next = frame_cnt + 4'd1;
                        state_next     = S_REQ;
                    end
                end
            end
            S_GEN:   state_next = S_CHECK;
            S_CHECK: state_next = S_APPLY;
            S_APPLY: state_next = S_REQ;
            S_REQ: begin
                watchdog_next = '0;
                if (draw_grant) begin
                    if (first_found) begin
                        sel_next   = first_idx;
                        state_next = S_DRAW;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DRAW: begin
                if (done_hit || (watchdog == 9'(DRAW_TIMEOUT - 1))) state_next = S_GAP;
                else watchdog_next = watchdog + 9'd1;
            end
            S_GAP: begin
                watchdog_next = '0;
                if (next_found) begin
                    sel_next   = next_idx;
                    state_next = S_DRAW;
                end else begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_WAIT;
            default: state_next = S_OFF;
        endcase

        if (start) state_next = S_INIT;

        // Outputs are decoded from the next state and registered, so they line up with state.
        init_next       = (state_next == S_INIT);
        idle_next       = (state_next == S_WAIT);
        gen_move_next   = (state_next == S_GEN);
        apply_move_next = (state_next == S_APPLY);
        frame_done_next = (state_next == S_DONE);
        draw_req_next   = (state_next == S_REQ) || (state_next == S_DRAW) || (state_next == S_GAP);
        draw_en_next    = (state_next == S_DRAW) ? (NUM_ENEMIES'(1) << sel_next) : '0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_OFF;
            frame_cnt  <= '0;
            pending    <= 1'b0;
            overrun    <= 1'b0;
            watchdog   <= '0;
            draw_sel   <= '0;
            init       <= 1'b0;
            idle       <= 1'b0;
            gen_move   <= 1'b0;
            apply_move <= 1'b0;
            draw_en    <= '0;
            draw_req   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            frame_cnt  <= frame_cnt_next;
            pending    <= pending_next;
            overrun    <= overrun_next;
            watchdog   <= watchdog_next;
            draw_sel   <= sel_next;
            init       <= init_next;
            idle       <= idle_next;
            gen_move   <= gen_move_next;
            apply_move <= apply_move_next;
            draw_en    <= draw_en_next;
            draw_req   <= draw_req_next;
            frame_done <= frame_done_next;
        end
    end

endmodule
